// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
//   - state_e    : responder FSM encoding (IDLE / BUSY / DONE)
//   - req_t      : latched request payload (direction + store data)
//   - sat_inc    : saturating increment for the completed-transaction counter
package dmem_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned CNT_W          = 4;   // holds LATENCY-1 for LATENCY up to 15
  localparam int unsigned REQ_CNT_W      = 16;
  localparam int unsigned DEF_DEPTH_LOG2 = 9;
  localparam int unsigned DEF_LATENCY    = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] wdata;
  } req_t;

  // Completed-transaction counter sticks at all-ones instead of wrapping.
  function automatic logic [REQ_CNT_W-1:0] sat_inc(input logic [REQ_CNT_W-1:0] v);
    return (v == {REQ_CNT_W{1'b1}}) ? v : v + REQ_CNT_W'(1);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and the responder (slave).
//   MemReqM/MemWriteM/AddrM/WriteDataM : request from the MEM stage
//   ReadDataM/AckM                     : load data and one-cycle completion pulse
//   StallMem                           : hold request to the hazard unit
//   ReqCount                           : saturating completed-transaction count
interface dmem_if;
  import dmem_pkg::*;

  logic                 MemReqM;
  logic                 MemWriteM;
  logic [WORD_W-1:0]    AddrM;
  logic [WORD_W-1:0]    WriteDataM;
  logic [WORD_W-1:0]    ReadDataM;
  logic                 AckM;
  logic                 StallMem;
  logic [REQ_CNT_W-1:0] ReqCount;

  modport master (
    output MemReqM, MemWriteM, AddrM, WriteDataM,
    input  ReadDataM, AckM, StallMem, ReqCount
  );

  modport slave (
    input  MemReqM, MemWriteM, AddrM, WriteDataM,
    output ReadDataM, AckM, StallMem, ReqCount
  );

endinterface

// File: rtl/dmem_responder_array.sv
// Single-port synchronous word RAM with a registered read-data port.
//   clk_i   : clock
//   rst_i   : async active-high reset, clears only the read-data register
//   en_i    : access enable for this edge
//   we_i    : 1 = write wdata_i, 0 = read
//   addr_i  : word index
//   wdata_i : store data
//   rdata_o : read data (write-through on writes), held between accesses
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  output logic [WORD_W-1:0]     rdata_o
);

  localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Storage array; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register; a write echoes the stored word so read-after-write is coherent.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= we_i ? wdata_i : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage.
// Captures one request in IDLE, counts LATENCY-1 cycles in BUSY, performs the
// RAM access on the final BUSY edge and pulses AckM for the single DONE cycle.
//   Clk, Reset : clock and async active-high reset
//   bus        : dmem_if slave modport (request in, data/ack/stall/count out)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int unsigned LATENCY    = DEF_LATENCY
) (
  input  logic Clk,
  input  logic Reset,
  dmem_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  req_t                   req_q, req_d;
  logic [DEPTH_LOG2-1:0]  addr_q, addr_d;
  logic                   ack_q, ack_d;
  logic [REQ_CNT_W-1:0]   count_q, count_d;
  logic                   ram_en_c;
  logic [WORD_W-1:0]      rdata_c;

  // Upper address bits are ignored so accesses wrap modulo the depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.AddrM[WORD_W-1:DEPTH_LOG2];

  // State and request registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; ack_d defaults low so AckM lasts exactly the DONE cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    addr_d   = addr_q;
    ack_d    = 1'b0;
    count_d  = count_q;
    ram_en_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.MemReqM) begin
          req_d.write = bus.MemWriteM;
          req_d.wdata = bus.WriteDataM;
          addr_d      = bus.AddrM[DEPTH_LOG2-1:0];
          cnt_d       = CNT_LOAD;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          // Access happens on the same edge that enters DONE.
          ram_en_c = 1'b1;
          ack_d    = 1'b1;
          count_d  = sat_inc(count_q);
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        // A request still present here belongs to the transaction just acked.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .en_i    (ram_en_c),
    .we_i    (req_q.write),
    .addr_i  (addr_q),
    .wdata_i (req_q.wdata),
    .rdata_o (rdata_c)
  );

  assign bus.ReadDataM = rdata_c;
  assign bus.AckM      = ack_q;
  assign bus.ReqCount  = count_q;
  // Stall drops in the Ack cycle so the pipeline advances; forced low in reset.
  assign bus.StallMem  = bus.MemReqM & ~ack_q & ~Reset;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dmem_if bus_a ();
  dmem_if bus_b ();

  dmem_responder #(.DEPTH_LOG2(9), .LATENCY(2)) dut_a (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus_a.slave)
  );

  dmem_responder #(.DEPTH_LOG2(9), .LATENCY(1)) dut_b (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive(input bit sel, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin
      bus_b.MemReqM = req; bus_b.MemWriteM = we; bus_b.AddrM = addr; bus_b.WriteDataM = wdata;
    end else begin
      bus_a.MemReqM = req; bus_a.MemWriteM = we; bus_a.AddrM = addr; bus_a.WriteDataM = wdata;
    end
  endtask

  // Issues one request at a negedge and waits (bounded) for its Ack.
  // lat = negedges from request to Ack cycle (LATENCY + 1 when idle at start).
  task automatic access(input bit sel, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int lat, output bit stall_bad, output bit stall_at_ack);
    bit got;
    got = 1'b0; lat = 0; stall_bad = 1'b0; stall_at_ack = 1'b1; rdata = '0;
    drive(sel, 1'b1, we, addr, wdata);
    #1;
    if (!(sel ? bus_b.StallMem : bus_a.StallMem)) stall_bad = 1'b1;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (sel ? bus_b.AckM : bus_a.AckM) begin
        got          = 1'b1;
        rdata        = sel ? bus_b.ReadDataM : bus_a.ReadDataM;
        stall_at_ack = sel ? bus_b.StallMem : bus_a.StallMem;
      end else if (!(sel ? bus_b.StallMem : bus_a.StallMem)) begin
        stall_bad = 1'b1;
      end
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    int acks;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus_a.AckM !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus_a.AckM); end
    checks++; if (bus_a.ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus_a.ReadDataM); end
    checks++; if (bus_a.ReqCount !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", bus_a.ReqCount); end
    checks++; if (bus_a.StallMem !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus_a.StallMem); end
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_a.AckM) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL idle_no_ack: got %0d acks expected 0", acks); end
    checks++; if (bus_a.ReqCount !== 16'h0) begin errors++; $display("FAIL idle_count: got %h expected 0", bus_a.ReqCount); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; int lat; bit sb, sa;
    access(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, rd, lat, sb, sa);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if (sb !== 1'b0) begin errors++; $display("FAIL wr_stall_busy: got low-stall flag %b expected 0", sb); end
    checks++; if (sa !== 1'b0) begin errors++; $display("FAIL wr_stall_ack: got %b expected 0", sa); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_echo: got %h expected deadbeef", rd); end
    checks++; if (bus_a.ReqCount !== 16'd1) begin errors++; $display("FAIL wr_count: got %0d expected 1", bus_a.ReqCount); end
    @(negedge clk);
    checks++; if (bus_a.AckM !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b expected 0", bus_a.AckM); end
    checks++; if (bus_a.ReadDataM !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %h expected deadbeef", bus_a.ReadDataM); end
    access(1'b0, 1'b0, 32'd5, 32'h0, rd, lat, sb, sa);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    checks++; if (bus_a.ReqCount !== 16'd2) begin errors++; $display("FAIL rd_count: got %0d expected 2", bus_a.ReqCount); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [31:0] rd; int lat; bit sb, sa;
    access(1'b0, 1'b1, 32'h205, 32'h12345678, rd, lat, sb, sa);
    @(negedge clk);
    access(1'b0, 1'b0, 32'd5, 32'h0, rd, lat, sb, sa);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL wrap_data: got %h expected 12345678", rd); end
    checks++; if (bus_a.ReqCount !== 16'd4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", bus_a.ReqCount); end
    @(negedge clk);
  endtask

  task automatic test_drop_mid_busy();
    logic [31:0] rd; int lat; bit sb, sa;
    int first_ack, acks, n;
    drive(1'b0, 1'b1, 1'b1, 32'd7, 32'hA5A5A5A5);
    @(negedge clk);
    // Request withdrawn and inputs scrambled while BUSY; latched values must win.
    drive(1'b0, 1'b0, 1'b0, 32'd8, 32'h0BAD0BAD);
    first_ack = -1; acks = 0; n = 0;
    repeat (8) begin
      @(negedge clk);
      n++;
      if (bus_a.AckM) begin
        acks++;
        if (first_ack < 0) first_ack = n;
      end
    end
    checks++; if (first_ack !== 2) begin errors++; $display("FAIL drop_ack_pos: got %0d expected 2", first_ack); end
    checks++; if (acks !== 1) begin errors++; $display("FAIL drop_ack_count: got %0d expected 1", acks); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    access(1'b0, 1'b0, 32'd7, 32'h0, rd, lat, sb, sa);
    checks++; if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL drop_data: got %h expected a5a5a5a5", rd); end
    checks++; if (bus_a.ReqCount !== 16'd6) begin errors++; $display("FAIL drop_count: got %0d expected 6", bus_a.ReqCount); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd; int lat; bit sb, sa;
    int acks;
    access(1'b0, 1'b1, 32'd9, 32'h00000001, rd, lat, sb, sa);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'd9, 32'hFFFF0000);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus_a.ReadDataM !== 32'h0) begin errors++; $display("FAIL async_rdata: got %h expected 0", bus_a.ReadDataM); end
    checks++; if (bus_a.ReqCount !== 16'h0) begin errors++; $display("FAIL async_count: got %h expected 0", bus_a.ReqCount); end
    checks++; if (bus_a.StallMem !== 1'b0) begin errors++; $display("FAIL async_stall: got %b expected 0", bus_a.StallMem); end
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_a.AckM) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rst_no_ack: got %0d acks expected 0", acks); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    access(1'b0, 1'b0, 32'd9, 32'h0, rd, lat, sb, sa);
    checks++; if (rd !== 32'h00000001) begin errors++; $display("FAIL rst_no_commit: got %h expected 00000001", rd); end
    checks++; if (bus_a.ReqCount !== 16'd1) begin errors++; $display("FAIL rst_count: got %0d expected 1", bus_a.ReqCount); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat; bit sb, sa;
    logic [31:0] exp_data [3];
    int pos [3];
    int idx, n;
    bit stall_err;
    exp_data[0] = 32'h11111111; exp_data[1] = 32'h22222222; exp_data[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      access(1'b1, 1'b1, 32'(i + 1), exp_data[i], rd, lat, sb, sa);
      @(negedge clk);
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lat1_latency: got %0d expected 2", lat); end
    // Clear the transaction counter; memory contents are kept.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    idx = 0; n = 0; stall_err = 1'b0;
    pos[0] = -1; pos[1] = -1; pos[2] = -1;
    drive(1'b1, 1'b1, 1'b0, 32'd1, 32'h0);
    while (n < 12 && idx < 3) begin
      @(negedge clk);
      n++;
      if (bus_b.AckM) begin
        pos[idx] = n;
        if (bus_b.StallMem !== 1'b0) stall_err = 1'b1;
        checks++;
        if (bus_b.ReadDataM !== exp_data[idx]) begin
          errors++; $display("FAIL b2b_data%0d: got %h expected %h", idx, bus_b.ReadDataM, exp_data[idx]);
        end
        idx++;
        if (idx < 3) drive(1'b1, 1'b1, 1'b0, 32'(idx + 1), 32'h0);
        else drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    // Acks at the 2nd, 5th and 8th cycle: two non-Ack cycles between pulses.
    checks++; if (pos[0] !== 2) begin errors++; $display("FAIL b2b_pos0: got %0d expected 2", pos[0]); end
    checks++; if (pos[1] !== 5) begin errors++; $display("FAIL b2b_pos1: got %0d expected 5", pos[1]); end
    checks++; if (pos[2] !== 8) begin errors++; $display("FAIL b2b_pos2: got %0d expected 8", pos[2]); end
    checks++; if (stall_err !== 1'b0) begin errors++; $display("FAIL b2b_stall_ack: got %b expected 0", stall_err); end
    checks++; if (bus_b.ReqCount !== 16'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", bus_b.ReqCount); end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_write_read();
    test_wrap();
    test_drop_mid_busy();
    test_reset_mid_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
